// File: rtl/traffic_light_ctrl.sv
// Phase controller for a two-road intersection with pedestrian crossing and night flash.
// Counts timebase ticks per phase and drives registered lamp outputs for both roads.
module traffic_light_ctrl #(
    parameter logic [3:0] TICK_MAX = 4'd9,
    parameter logic [7:0] INIT_T   = 8'd2,
    parameter logic [7:0] G_T      = 8'd6,
    parameter logic [7:0] Y_T      = 8'd2,
    parameter logic [7:0] AR_T     = 8'd1,
    parameter logic [7:0] PED_T    = 8'd4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    output logic       timer_ready,
    output logic [3:0] tick_max,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_NS_G  = 4'd1,
        S_NS_Y  = 4'd2,
        S_AR1   = 4'd3,
        S_EW_G  = 4'd4,
        S_EW_Y  = 4'd5,
        S_AR2   = 4'd6,
        S_PED   = 4'd7,
        S_FLASH = 4'd8
    } state_t;

    state_t     state_q, state_d;
    state_t     timed_next_s;
    logic [7:0] dur_s;
    logic       valid_s;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic       ped_pending_q, ped_pending_d;
    logic       flash_on_q, flash_on_d;
    logic       ped_entry_s;

    // Last tick_cnt value of a phase; a zero duration behaves like one tick.
    function automatic logic [7:0] last_cnt(input logic [7:0] dur);
        if (dur == 8'd0) begin
            return 8'd0;
        end else begin
            return dur - 8'd1;
        end
    endfunction

    // Lamp pattern {ns, ew, walk} for a given state.
    function automatic logic [6:0] lamps(input state_t s, input logic f);
        case (s)
            S_NS_G:  return {3'b001, 3'b100, 1'b0};
            S_NS_Y:  return {3'b010, 3'b100, 1'b0};
            S_EW_G:  return {3'b100, 3'b001, 1'b0};
            S_EW_Y:  return {3'b100, 3'b010, 1'b0};
            S_PED:   return {3'b100, 3'b100, 1'b1};
            S_FLASH: return {1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0};
            default: return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    // Duration and successor of the current timed phase.
    always_comb begin
        dur_s        = 8'd1;
        timed_next_s = S_INIT;
        valid_s      = 1'b1;
        case (state_q)
            S_INIT:  begin dur_s = INIT_T; timed_next_s = S_NS_G; end
            S_NS_G:  begin dur_s = G_T;    timed_next_s = S_NS_Y; end
            S_NS_Y:  begin dur_s = Y_T;    timed_next_s = S_AR1;  end
            S_AR1:   begin dur_s = AR_T;   timed_next_s = night_mode ? S_FLASH : S_EW_G; end
            S_EW_G:  begin dur_s = G_T;    timed_next_s = S_EW_Y; end
            S_EW_Y:  begin dur_s = Y_T;    timed_next_s = S_AR2;  end
            S_AR2: begin
                dur_s = AR_T;
                // Night mode outranks a waiting pedestrian.
                if (night_mode) begin
                    timed_next_s = S_FLASH;
                end else if (ped_pending_q) begin
                    timed_next_s = S_PED;
                end else begin
                    timed_next_s = S_NS_G;
                end
            end
            S_PED:   begin dur_s = PED_T;  timed_next_s = S_NS_G; end
            S_FLASH: begin dur_s = 8'd1;   timed_next_s = S_FLASH; end
            default: begin dur_s = 8'd1;   timed_next_s = S_INIT; valid_s = 1'b0; end
        endcase
    end

    // Next state, tick counter, flash phase and pedestrian latch.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        flash_on_d = flash_on_q;
        if (!valid_s) begin
            state_d    = S_INIT;
            tick_cnt_d = 8'd0;
            flash_on_d = 1'b0;
        end else if (state_q == S_FLASH) begin
            if (tick && night_mode) begin
                flash_on_d = ~flash_on_q;
            end else if (tick) begin
                state_d    = S_INIT;
                tick_cnt_d = 8'd0;
                flash_on_d = 1'b0;
            end else begin
                flash_on_d = flash_on_q;
            end
        end else if (tick) begin
            if (tick_cnt_q == last_cnt(dur_s)) begin
                state_d    = timed_next_s;
                tick_cnt_d = 8'd0;
            end else begin
                tick_cnt_d = tick_cnt_q + 8'd1;
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
        ped_entry_s   = (state_d == S_PED) && (state_q != S_PED);
        ped_pending_d = ped_req | (ped_pending_q & ~ped_entry_s);
    end

    // State register and registered lamp outputs, updated on the same edge.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q       <= S_INIT;
            tick_cnt_q    <= 8'd0;
            ped_pending_q <= 1'b0;
            flash_on_q    <= 1'b0;
            timer_ready   <= 1'b0;
            ns_light      <= 3'b100;
            ew_light      <= 3'b100;
            ped_walk      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            ped_pending_q <= ped_pending_d;
            flash_on_q    <= flash_on_d;
            timer_ready   <= 1'b1;
            {ns_light, ew_light, ped_walk} <= lamps(state_d, flash_on_d);
        end
    end

    assign phase    = state_q;
    assign tick_max = TICK_MAX;

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Phase controller for a two-road intersection (north-south, east-west) with a pedestrian crossing and a night flash mode. Sits directly downstream of the team's tick counter. It drives that counter's ready and max_count inputs, consumes its overflow pulse as a timebase tick, and counts ticks per phase. It produces registered lamp drives for both roads plus the pedestrian walk signal.

Parameters:
TICK_MAX, 4'd9, constant driven on tick_max; one tick = TICK_MAX+1 clk cycles at the counter
INIT_T, 8'd2, ticks in start-up all-red
G_T, 8'd6, ticks in each green phase
Y_T, 8'd2, ticks in each yellow phase
AR_T, 8'd1, ticks in each all-red clearance phase
PED_T, 8'd4, ticks in pedestrian walk phase

Ports:
clk  in  1  clock
resetN  in  1  reset, asynchronous, active-high
tick  in  1  timebase pulse (counter overflow)
timer_ready  out  1  enable to counter ready input
tick_max  out  4  to counter max_count input
ped_req  in  1  pedestrian button, any width pulse
night_mode  in  1  request flash operation
ns_light  out  3  {red,yellow,green} north-south
ew_light  out  3  {red,yellow,green} east-west
ped_walk  out  1  walk lamp
phase  out  4  current state encoding, for debug/monitor

Behaviour:
- Reset (asynchronous, active-high resetN): state=INIT, tick_cnt=0, ped_pending=0, flash_on=0, timer_ready=0, tick_max=TICK_MAX, ns_light=ew_light=3'b100, ped_walk=0, phase=0.
- timer_ready goes to 1 on the first clk edge after resetN falls and is held at 1 until the next reset. tick_max is constant TICK_MAX.
- States and phase codes:
  - INIT=0, NS_G=1, NS_Y=2, AR1=3, EW_G=4, EW_Y=5, AR2=6, PED=7, FLASH=8.
  - Codes 9-15 are unreachable and recover to INIT on the next clk.
- Timed-state rule: tick_cnt (8 bit) is cleared on every state entry. In a cycle with tick=1:
  - if tick_cnt==DUR-1, transition and clear tick_cnt;
  - otherwise tick_cnt+1.
  - A duration parameter of 0 is treated as 1.
  - Each clk cycle with tick high counts once; there is no edge detection. If tick is held high, a state lasts exactly DUR cycles.
- Transitions:
  - INIT -> NS_G after INIT_T.
  - NS_G -> NS_Y after G_T.
  - NS_Y -> AR1 after Y_T.
  - AR1 -> FLASH if night_mode=1 at exit, else EW_G (after AR_T).
  - EW_G -> EW_Y after G_T.
  - EW_Y -> AR2 after Y_T.
  - AR2 (after AR_T): FLASH if night_mode=1, else PED if ped_pending=1, else NS_G. Night mode has priority over pedestrian.
  - PED -> NS_G after PED_T.
  - FLASH: on each tick, flash_on toggles. On a tick with night_mode=0, go to INIT and set flash_on=0.
- Outputs are registered and change on the same edge as the state register:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - INIT/AR1/AR2/PED: both 100.
  - FLASH: both {0,flash_on,0}.
  - ped_walk=1 only in PED.
- ped_pending:
  - set on any cycle with ped_req=1;
  - cleared on the edge entering PED;
  - set has priority if ped_req=1 on that same edge;
  - a request made during FLASH stays pending.
- night_mode is sampled only at AR1/AR2 exits and on FLASH ticks. It never interrupts a green or yellow phase.
- Reset mid-operation: immediate return to reset values. tick_cnt and ped_pending are lost.

Test Plan:
- Reset held 3 cycles then released, tick=0 -> all outputs at reset values during reset; timer_ready=1 one cycle after release; tick_max=9 throughout; phase stays 0.
- tick held high, defaults, no requests -> phase sequence 0(2 cyc),1(6),2(2),3(1),4(6),5(2),6(1),1... Lights match the table on each edge; ns and ew are never both non-red.
- tick pulsed one cycle in every 10 -> NS_G lasts exactly 60 cycles; non-tick cycles never advance tick_cnt.
- ped_req 1-cycle pulse during NS_G, tick high -> after AR2, phase=7 for 4 cycles with ped_walk=1 and both roads red, then NS_G. A second ped_req on the PED-entry edge -> PED again on the following AR2.
- night_mode=1 asserted mid EW_G -> EW_G and EW_Y complete; at AR2 exit phase=8 and yellows toggle 000/010 each tick. night_mode=0 -> INIT on the next tick, then normal sequence.
- resetN pulsed during EW_Y with ped_pending=1 -> asynchronous return to phase 0, lights 100/100, ped_pending cleared; no PED phase on the next cycle.
